div_hilo_ctrl: RTL and testbench
================================

# div_hilo_ctrl

Sequencing controller between the EX stage and the 16-bit iterative divider of the pipelined MIPS core. Accepts DIV requests from EX, launches the divider, and tracks its start/ready handshake. Writes quotient/remainder into architectural LO/HI registers and stalls the pipeline only when an instruction depends on an in-flight divide. Also serves MFHI/MFLO reads and MTHI/MTLO writes.

## Interface
- DRAIN_CYCLES, 20, cycles spent in DRAIN after reset; must be ≥ divider worst-case latency (19).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- div_req  in  1  EX issues a DIV this cycle
- dividend  in  16  DIV operand rs
- divisor  in  16  DIV operand rt
- hilo_rd  in  1  EX issues MFHI/MFLO this cycle
- rd_hi  in  1  1 = read HI, 0 = read LO
- rd_data  out  16  combinational HI or LO per rd_hi
- wr_hi / wr_lo  in  1 each  MTHI / MTLO strobe
- wr_data  in  16  MTHI/MTLO data
- stall  out  1  hold IF/ID/EX this cycle (combinational)
- div_start  out  1  to divider start; high only in LAUNCH
- div_dividend / div_divisor  out  16 each  latched operands to divider
- div_ready  in  1  divider ready
- div_result  in  32  divider result {quotient[15:0], remainder[15:0]}
- busy  out  1  state ≠ IDLE
- div_zero  out  1  sticky flag, last DIV had divisor 0 (see Configuration)

## Operation
- States: DRAIN, IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH.
- Reset: state = DRAIN, drain counter = 0, hi = lo = 0, operand regs = 0, div_zero = 0. Outputs: stall = 0 unless a request arrives, div_start = 0, busy = 1.
- DRAIN: count to DRAIN_CYCLES-1, then go to IDLE. Lets a divider that has no reset finish any op orphaned by a mid-operation reset.
- IDLE, div_req = 1: latch dividend/divisor, go to LAUNCH.
- LAUNCH: div_start = 1, go to WAIT_LOW.
- WAIT_LOW: when div_ready = 0, go to WAIT_HIGH. Guards against the stale ready level left from the previous op.
- WAIT_HIGH: when div_ready = 1, set lo ← div_result[31:16] (quotient) and hi ← div_result[15:0] (remainder), then go to IDLE.
- stall = (state ≠ IDLE) & (div_req | hilo_rd | wr_hi | wr_lo). Independent instructions flow while a divide is in flight.
- MTHI/MTLO in IDLE: write on the clock edge. In IDLE, a simultaneous DIV accept and MT write are both performed. The DIV result later overwrites the MT value.
- Operands are unsigned. No sign handling in this block.
- Reset asserted in any state: immediately return to DRAIN. The in-flight result is discarded and hi/lo are cleared.

## Timing
- Let E0 be the edge that samples div_req in IDLE. Then E1 = LAUNCH, and the divider samples start at E1.
- div_ready falls after E1. WAIT_LOW sees it at E2.
- div_ready rises after E19. hi/lo are written at E20 and state is IDLE after E20.
- A dependent instruction presented after E0 stalls through the cycle ending at E20. Total DIV-to-DIV throughput is 20 cycles.
- rd_data is combinational. A read in the cycle after E20 returns the new value.
- After rst deasserts, the first DIV can be accepted at edge DRAIN_CYCLES. Earlier requests are stalled, not dropped.

## Configuration
- DIV_ZERO_TRAP_EN defined:
  - IDLE with div_req and divisor == 0 skips the divider.
  - Sets lo ← 16'hFFFF, hi ← dividend and div_zero ← 1 at E0, staying in IDLE.
  - A nonzero DIV clears div_zero when accepted.
- DIV_ZERO_TRAP_EN undefined:
  - Zero divisors go through the full divider sequence and take the divider's natural result.
  - div_zero is tied to 0.

## Test plan
- Reset, wait DRAIN_CYCLES, DIV 100/7 → lo = 14, hi = 2 after E20. stall high exactly for a dependent MFLO issued at E1, and rd_data = 14 in the cycle after E20.
- DIV 0xFFFF/0x0001 then DIV 5/9 back-to-back → first gives lo = 0xFFFF, hi = 0. Second request is stalled until the first completes, then gives lo = 0, hi = 5.
- Independent traffic (div_req = hilo_rd = wr_* = 0) during WAIT_HIGH → stall stays 0. MTHI 0x1234 in IDLE then MFHI → rd_data = 0x1234.
- Reset asserted at E10 of a DIV → hi = lo = 0 and state DRAIN. A DIV 9/3 issued during DRAIN is stalled until drain ends, then gives lo = 3, hi = 0. No stale result is written.
- DIV 42/0 with DIV_ZERO_TRAP_EN → lo = 0xFFFF, hi = 42, div_zero = 1 in one cycle, no div_start pulse. Without the macro → 20-cycle sequence and div_zero = 0.
- Hold div_ready high before launch → controller waits in WAIT_LOW until it falls. It does not capture div_result early.

Source files
------------

// File: rtl/div_hilo_ctrl_if.sv
// div_hilo_ctrl_if: groups the EX-side request/HILO bus and the divider
// handshake that connect to div_hilo_ctrl.
// slave  = controller side, master = pipeline + divider side.
interface div_hilo_ctrl_if;
   logic        div_req;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        hilo_rd;
   logic        rd_hi;
   logic [15:0] rd_data;
   logic        wr_hi;
   logic        wr_lo;
   logic [15:0] wr_data;
   logic        stall;
   logic        div_start;
   logic [15:0] div_dividend;
   logic [15:0] div_divisor;
   logic        div_ready;
   logic [31:0] div_result;
   logic        busy;
   logic        div_zero;

   modport slave (
      input  div_req, dividend, divisor, hilo_rd, rd_hi, wr_hi, wr_lo, wr_data,
             div_ready, div_result,
      output rd_data, stall, div_start, div_dividend, div_divisor, busy, div_zero
   );

   modport master (
      output div_req, dividend, divisor, hilo_rd, rd_hi, wr_hi, wr_lo, wr_data,
             div_ready, div_result,
      input  rd_data, stall, div_start, div_dividend, div_divisor, busy, div_zero
   );
endinterface

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequences DIV requests from EX onto a 16-bit iterative
// divider, owns the architectural HI/LO registers, serves MFHI/MFLO and
// MTHI/MTLO, and stalls only instructions that touch HI/LO or the divider
// while a divide is in flight.
// Optional feature: define DIV_ZERO_TRAP_EN to resolve divide-by-zero in
// IDLE without using the divider (lo = 16'hFFFF, hi = dividend, sticky
// div_zero). Without it div_zero is tied low.
module div_hilo_ctrl #(
   parameter int DRAIN_CYCLES = 20
) (
   input  logic            clk,
   input  logic            rst,
   div_hilo_ctrl_if.slave  bus
);
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_DRAIN, S_IDLE, S_LAUNCH, S_WAIT_LOW, S_WAIT_HIGH
   } state_t;

   state_t        r_state, w_next;
   logic [CW-1:0] r_drain_cnt;
   logic [15:0]   r_hi, r_lo;
   logic [15:0]   r_opa, r_opb;
   logic          w_accept, w_zero_trap, w_launch, w_done;
   logic          w_start, w_busy;

   assign w_accept = (r_state == S_IDLE) & bus.div_req;
   assign w_done   = (r_state == S_WAIT_HIGH) & bus.div_ready;

`ifdef DIV_ZERO_TRAP_EN
   logic r_div_zero;
   assign w_zero_trap = w_accept & (bus.divisor == 16'd0);

   // Sticky divide-by-zero flag; any accepted nonzero DIV clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              r_div_zero <= 1'b0;
      else if (w_zero_trap) r_div_zero <= 1'b1;
      else if (w_accept)    r_div_zero <= 1'b0;
   end
   assign bus.div_zero = r_div_zero;
`else
   assign w_zero_trap  = 1'b0;
   assign bus.div_zero = 1'b0;
`endif

   assign w_launch = w_accept & ~w_zero_trap;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_DRAIN;
      else     r_state <= w_next;
   end

   // Next-state and divider/pipeline control outputs
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_busy  = 1'b1;
      case (r_state)
         S_DRAIN:     if (r_drain_cnt == DRAIN_LAST) w_next = S_IDLE;
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_launch) w_next = S_LAUNCH;
         end
         S_LAUNCH: begin
            w_start = 1'b1;
            w_next  = S_WAIT_LOW;
         end
         // ready is still high from the previous op; wait for the divider
         // to acknowledge start by dropping it
         S_WAIT_LOW:  if (!bus.div_ready) w_next = S_WAIT_HIGH;
         S_WAIT_HIGH: if (bus.div_ready)  w_next = S_IDLE;
         default:     w_next = S_DRAIN;
      endcase
   end

   // Drain counter: gives an unreset divider time to finish an orphaned op
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_drain_cnt <= '0;
      else if (r_state == S_DRAIN && r_drain_cnt != DRAIN_LAST)
         r_drain_cnt <= r_drain_cnt + CW'(1);
   end

   // Operand latch, held stable for the divider for the whole op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opa <= '0;
         r_opb <= '0;
      end else if (w_launch) begin
         r_opa <= bus.dividend;
         r_opb <= bus.divisor;
      end
   end

   // HI/LO: MT writes only land in IDLE (stalled otherwise); a DIV result
   // written later simply overwrites an MT value taken on the accept edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            if (bus.wr_hi) r_hi <= bus.wr_data;
            if (bus.wr_lo) r_lo <= bus.wr_data;
         end
         if (w_zero_trap) begin
            r_lo <= 16'hFFFF;
            r_hi <= bus.dividend;
         end
         if (w_done) begin
            r_lo <= bus.div_result[31:16];
            r_hi <= bus.div_result[15:0];
         end
      end
   end

   assign bus.stall        = w_busy & (bus.div_req | bus.hilo_rd | bus.wr_hi | bus.wr_lo);
   assign bus.busy         = w_busy;
   assign bus.div_start    = w_start;
   assign bus.div_dividend = r_opa;
   assign bus.div_divisor  = r_opb;
   assign bus.rd_data      = bus.rd_hi ? r_hi : r_lo;
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: directed bench for div_hilo_ctrl with a behavioural
// divider (ready drops after the start edge, rises 18 edges later).
module tb_div_hilo_ctrl;
   localparam int DRAIN = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_hilo_ctrl_if bus();

   div_hilo_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural divider, deliberately not reset (like the real one)
   logic        m_ready = 1'b1;
   logic [4:0]  m_cnt   = 5'd0;
   logic [31:0] m_res   = 32'd0;
   logic        hold    = 1'b0;
   always @(posedge clk) begin
      if (bus.div_start) begin
         m_ready <= 1'b0;
         m_cnt   <= 5'd18;
         if (bus.div_divisor == 16'd0) m_res <= {16'hFFFF, bus.div_dividend};
         else m_res <= {bus.div_dividend / bus.div_divisor, bus.div_dividend % bus.div_divisor};
      end else if (m_cnt != 5'd0) begin
         m_cnt <= m_cnt - 5'd1;
         if (m_cnt == 5'd1) m_ready <= 1'b1;
      end
   end
   assign bus.div_ready  = hold | m_ready;
   assign bus.div_result = hold ? 32'hDEADBEEF : m_res;

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs;
      bus.div_req = 1'b0; bus.dividend = 16'd0; bus.divisor = 16'd0;
      bus.hilo_rd = 1'b0; bus.rd_hi = 1'b0;
      bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = 16'd0;
   endtask

   // Runs until busy drops (sampled on negedge); counts busy cycles and starts
   task automatic run_to_idle(output int nb, output int st, output bit ok);
      nb = 0; st = 0; ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!bus.busy) begin ok = 1'b1; break; end
         nb++;
         if (bus.div_start) st++;
         step;
      end
   endtask

   task automatic test_reset;
      clear_inputs;
      rst = 1'b1;
      repeat (3) step;
      @(negedge clk);
      n_chk++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy); else n_pass++;
      n_chk++; if (bus.div_start !== 1'b0) $display("FAIL reset_start: got %b want 0", bus.div_start); else n_pass++;
      n_chk++; if (bus.stall !== 1'b0) $display("FAIL reset_stall_idle: got %b want 0", bus.stall); else n_pass++;
      n_chk++; if (bus.rd_data !== 16'h0) $display("FAIL reset_lo: got %h want 0000", bus.rd_data); else n_pass++;
      n_chk++; if (bus.div_zero !== 1'b0) $display("FAIL reset_divzero: got %b want 0", bus.div_zero); else n_pass++;
      bus.rd_hi = 1'b1; bus.hilo_rd = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'h0) $display("FAIL reset_hi: got %h want 0000", bus.rd_data); else n_pass++;
      n_chk++; if (bus.stall !== 1'b1) $display("FAIL reset_stall_req: got %b want 1", bus.stall); else n_pass++;
      bus.hilo_rd = 1'b0; bus.rd_hi = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (DRAIN - 1) step;
      @(negedge clk);
      n_chk++; if (bus.busy !== 1'b1) $display("FAIL drain_busy_19: got %b want 1", bus.busy); else n_pass++;
      step;
      @(negedge clk);
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL drain_idle_20: got %b want 0", bus.busy); else n_pass++;
   endtask

   task automatic test_div_basic;
      int ns, st;
      step;
      bus.div_req = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
      @(negedge clk);
      n_chk++; if (bus.stall !== 1'b0) $display("FAIL basic_accept_stall: got %b want 0", bus.stall); else n_pass++;
      step;  // E0
      bus.div_req = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.div_start !== 1'b1) $display("FAIL basic_start: got %b want 1", bus.div_start); else n_pass++;
      n_chk++; if ({bus.div_dividend, bus.div_divisor} !== {16'd100, 16'd7})
         $display("FAIL basic_operands: got %0d/%0d want 100/7", bus.div_dividend, bus.div_divisor); else n_pass++;
      step;  // E1: dependent MFLO presented
      bus.hilo_rd = 1'b1; bus.rd_hi = 1'b0;
      ns = 0; st = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.stall) break;
         ns++;
         if (bus.div_start) st++;
         step;
      end
      n_chk++; if (ns !== 19) $display("FAIL basic_stall_len: got %0d want 19", ns); else n_pass++;
      n_chk++; if (st !== 0) $display("FAIL basic_extra_start: got %0d want 0", st); else n_pass++;
      n_chk++; if (bus.rd_data !== 16'd14) $display("FAIL basic_lo: got %0d want 14", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'd2) $display("FAIL basic_hi: got %0d want 2", bus.rd_data); else n_pass++;
      bus.hilo_rd = 1'b0; bus.rd_hi = 1'b0;
   endtask

   task automatic test_back_to_back;
      int ns, nb, st;
      bit ok;
      step;
      bus.div_req = 1'b1; bus.dividend = 16'hFFFF; bus.divisor = 16'h0001;
      step;  // E0 of first
      bus.dividend = 16'd5; bus.divisor = 16'd9;
      ns = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.stall) break;
         ns++;
         step;
      end
      n_chk++; if (ns !== 20) $display("FAIL b2b_stall_len: got %0d want 20", ns); else n_pass++;
      bus.rd_hi = 1'b0; #1;
      n_chk++; if (bus.rd_data !== 16'hFFFF) $display("FAIL b2b_lo1: got %h want ffff", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'h0000) $display("FAIL b2b_hi1: got %h want 0000", bus.rd_data); else n_pass++;
      step;  // second accepted
      bus.div_req = 1'b0;
      run_to_idle(nb, st, ok);
      n_chk++; if (ok !== 1'b1 || nb !== 20) $display("FAIL b2b_busy2: got ok=%0b cycles=%0d want 1/20", ok, nb); else n_pass++;
      bus.rd_hi = 1'b0; #1;
      n_chk++; if (bus.rd_data !== 16'd0) $display("FAIL b2b_lo2: got %0d want 0", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'd5) $display("FAIL b2b_hi2: got %0d want 5", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b0;
   endtask

   task automatic test_independent;
      int bad, nb, st;
      bit ok;
      step;
      bus.div_req = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd5;
      step;
      bus.div_req = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         if (bus.stall) bad++;
         step;
      end
      n_chk++; if (bad !== 0 || bus.busy !== 1'b0) $display("FAIL indep_stall: got %0d stalled (busy=%b) want 0", bad, bus.busy); else n_pass++;
      bus.rd_hi = 1'b0; #1;
      n_chk++; if (bus.rd_data !== 16'd10) $display("FAIL indep_lo: got %0d want 10", bus.rd_data); else n_pass++;
      step;
      bus.wr_hi = 1'b1; bus.wr_data = 16'h1234;
      step;
      bus.wr_hi = 1'b0; bus.hilo_rd = 1'b1; bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'h1234) $display("FAIL mthi_mfhi: got %h want 1234", bus.rd_data); else n_pass++;
      n_chk++; if (bus.stall !== 1'b0) $display("FAIL mfhi_stall: got %b want 0", bus.stall); else n_pass++;
      bus.hilo_rd = 1'b0; bus.rd_hi = 1'b0; #1;
      n_chk++; if (bus.rd_data !== 16'd10) $display("FAIL mthi_lo_kept: got %0d want 10", bus.rd_data); else n_pass++;
      // MTLO and DIV accepted on the same edge
      step;
      bus.wr_lo = 1'b1; bus.wr_data = 16'hAAAA;
      bus.div_req = 1'b1; bus.dividend = 16'd21; bus.divisor = 16'd4;
      step;
      bus.wr_lo = 1'b0; bus.div_req = 1'b0; #1;
      n_chk++; if (bus.rd_data !== 16'hAAAA || bus.busy !== 1'b1)
         $display("FAIL mt_div_same: got lo=%h busy=%b want aaaa/1", bus.rd_data, bus.busy); else n_pass++;
      run_to_idle(nb, st, ok);
      n_chk++; if (ok !== 1'b1) $display("FAIL mt_div_timeout: got %b want 1", ok); else n_pass++;
      #1;
      n_chk++; if (bus.rd_data !== 16'd5) $display("FAIL mt_div_lo: got %0d want 5", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'd1) $display("FAIL mt_div_hi: got %0d want 1", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b0;
   endtask

   task automatic test_reset_mid;
      int ns, nb, st;
      bit ok;
      step;
      bus.div_req = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd3;
      step;  // E0
      bus.div_req = 1'b0;
      repeat (9) step;
      rst = 1'b1; bus.rd_hi = 1'b0; #1;
      n_chk++; if (bus.busy !== 1'b1 || bus.div_start !== 1'b0)
         $display("FAIL rstmid_state: got busy=%b start=%b want 1/0", bus.busy, bus.div_start); else n_pass++;
      n_chk++; if (bus.rd_data !== 16'd0) $display("FAIL rstmid_lo: got %0d want 0", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'd0) $display("FAIL rstmid_hi: got %0d want 0", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b0;
      step; step;
      rst = 1'b0;
      bus.div_req = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
      ns = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.stall) break;
         ns++;
         step;
      end
      n_chk++; if (ns !== DRAIN) $display("FAIL rstmid_drain_stall: got %0d want %0d", ns, DRAIN); else n_pass++;
      n_chk++; if (bus.rd_data !== 16'd0) $display("FAIL rstmid_no_stale: got %0d want 0", bus.rd_data); else n_pass++;
      step;
      bus.div_req = 1'b0;
      run_to_idle(nb, st, ok);
      n_chk++; if (ok !== 1'b1 || st !== 1) $display("FAIL rstmid_run: got ok=%b starts=%0d want 1/1", ok, st); else n_pass++;
      #1;
      n_chk++; if (bus.rd_data !== 16'd3) $display("FAIL rstmid_lo2: got %0d want 3", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'd0) $display("FAIL rstmid_hi2: got %0d want 0", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b0;
   endtask

   task automatic test_div_zero;
      int nb, st;
      bit ok;
      step;
      bus.div_req = 1'b1; bus.dividend = 16'd42; bus.divisor = 16'd0;
      step;  // E0
      bus.div_req = 1'b0;
      run_to_idle(nb, st, ok);
`ifdef DIV_ZERO_TRAP_EN
      n_chk++; if (ok !== 1'b1 || nb !== 0 || st !== 0)
         $display("FAIL dz_trap_seq: got ok=%b cycles=%0d starts=%0d want 1/0/0", ok, nb, st); else n_pass++;
      n_chk++; if (bus.div_zero !== 1'b1) $display("FAIL dz_flag: got %b want 1", bus.div_zero); else n_pass++;
`else
      n_chk++; if (ok !== 1'b1 || nb !== 20 || st !== 1)
         $display("FAIL dz_full_seq: got ok=%b cycles=%0d starts=%0d want 1/20/1", ok, nb, st); else n_pass++;
      n_chk++; if (bus.div_zero !== 1'b0) $display("FAIL dz_flag: got %b want 0", bus.div_zero); else n_pass++;
`endif
      bus.rd_hi = 1'b0; #1;
      n_chk++; if (bus.rd_data !== 16'hFFFF) $display("FAIL dz_lo: got %h want ffff", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'd42) $display("FAIL dz_hi: got %0d want 42", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b0;
      // a nonzero DIV clears the flag on accept
      step;
      bus.div_req = 1'b1; bus.dividend = 16'd8; bus.divisor = 16'd2;
      step;
      bus.div_req = 1'b0; #1;
      n_chk++; if (bus.div_zero !== 1'b0) $display("FAIL dz_clear: got %b want 0", bus.div_zero); else n_pass++;
      run_to_idle(nb, st, ok);
      #1;
      n_chk++; if (ok !== 1'b1 || bus.rd_data !== 16'd4) $display("FAIL dz_next_lo: got ok=%b lo=%0d want 1/4", ok, bus.rd_data); else n_pass++;
   endtask

   task automatic test_ready_held;
      int nb, st;
      bit ok;
      step;
      bus.wr_lo = 1'b1; bus.wr_data = 16'h5A5A;
      step;
      bus.wr_lo = 1'b0;
      hold = 1'b1;
      bus.div_req = 1'b1; bus.dividend = 16'd77; bus.divisor = 16'd7;
      step;  // E0
      bus.div_req = 1'b0;
      repeat (6) step;
      @(negedge clk);
      bus.rd_hi = 1'b0;
      n_chk++; if (bus.busy !== 1'b1) $display("FAIL held_busy: got %b want 1", bus.busy); else n_pass++;
      #1;
      n_chk++; if (bus.rd_data !== 16'h5A5A) $display("FAIL held_no_capture: got %h want 5a5a", bus.rd_data); else n_pass++;
      hold = 1'b0;
      step;
      run_to_idle(nb, st, ok);
      #1;
      n_chk++; if (ok !== 1'b1 || bus.rd_data !== 16'd11) $display("FAIL held_lo: got ok=%b lo=%0d want 1/11", ok, bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b1; #1;
      n_chk++; if (bus.rd_data !== 16'd0) $display("FAIL held_hi: got %0d want 0", bus.rd_data); else n_pass++;
      bus.rd_hi = 1'b0;
   endtask

   initial begin
      test_reset;
      test_div_basic;
      test_back_to_back;
      test_independent;
      test_reset_mid;
      test_div_zero;
      test_ready_held;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_chk);
      $fatal(1);
   end
endmodule
